// File: rtl/adc_i2s_rx.sv
// adc_i2s_rx: deserialises the codec adcdat stream into {left,right} frames buffered in a
// first-word-fall-through FIFO. Define ADC_I2S_RX_LJ_EN for left-justified input instead of I2S.
module adc_i2s_rx #(
    parameter int DW          = 16,
    parameter int FIFO_AW     = 2,
    parameter int SYNC_STAGES = 2
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            b_clk,
    input  logic            adc_lr_clk,
    input  logic            adcdat,
    input  logic            rd,
    input  logic            clr_err,
    output logic [2*DW-1:0] adc_data_out,
    output logic            empty,
    output logic            full,
    output logic            sample_tick,
    output logic            overrun,
    output logic            frame_err
);

    localparam int              DEPTH     = 2**FIFO_AW;
    localparam int              CW        = (DW > 1) ? $clog2(DW) : 1;
    localparam logic [CW-1:0]   CNT_LAST  = CW'(DW - 1);
    localparam logic [FIFO_AW:0] CNT_FULL = (FIFO_AW + 1)'(DEPTH);
`ifdef ADC_I2S_RX_LJ_EN
    localparam bit LJ = 1'b1;
`else
    localparam bit LJ = 1'b0;
`endif

    typedef enum logic [2:0] {
        IDLE, DLY_L, SHIFT_L, WAIT_R, DLY_R, SHIFT_R, PUSH, WAIT_L
    } state_t;

    logic [SYNC_STAGES-1:0] bclk_sync, lr_sync, dat_sync;
    logic                   bclk_d, lr_d;
    logic                   bclk_s, lr_s, dat_s;
    logic                   bclk_rise, lr_rise, lr_fall;

    state_t          state, state_n;
    logic [CW-1:0]   cnt, cnt_n;
    logic            bad, bad_n, pend, pend_n;
    logic            shift_l, shift_r, err_evt, push, cnt_last;
    logic [DW-1:0]   sh_l, sh_r;

    logic [2*DW-1:0] mem [DEPTH];
    logic [FIFO_AW-1:0] wptr, rptr;
    logic [FIFO_AW:0]   count;
    logic            rd_ok, wr_ok, ovf_evt;

    // Identical chain depths keep bit clock, frame clock and data aligned after synchronisation.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bclk_sync <= '0;
            lr_sync   <= '0;
            dat_sync  <= '0;
            bclk_d    <= 1'b0;
            lr_d      <= 1'b0;
        end else begin
            bclk_sync <= {bclk_sync[SYNC_STAGES-2:0], b_clk};
            lr_sync   <= {lr_sync[SYNC_STAGES-2:0], adc_lr_clk};
            dat_sync  <= {dat_sync[SYNC_STAGES-2:0], adcdat};
            bclk_d    <= bclk_s;
            if (bclk_rise) lr_d <= lr_s;
        end
    end

    assign bclk_s    = bclk_sync[SYNC_STAGES-1];
    assign lr_s      = lr_sync[SYNC_STAGES-1];
    assign dat_s     = dat_sync[SYNC_STAGES-1];
    assign bclk_rise = bclk_s & ~bclk_d;
    assign lr_rise   = bclk_rise & ~lr_d & lr_s;
    assign lr_fall   = bclk_rise & lr_d & ~lr_s;
    assign cnt_last  = (cnt == CNT_LAST);

    // The bit clock rise that reveals an LR edge carries the I2S delay slot, or the MSB when
    // left-justified; in I2S the previous channel's LSB shares that rise.
    // NOTE: every output of this block gets a default first so no latch is inferred.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        bad_n   = bad;
        pend_n  = pend;
        shift_l = 1'b0;
        shift_r = 1'b0;
        err_evt = 1'b0;
        push    = 1'b0;
        unique case (state)
            IDLE, WAIT_L: begin
                if (lr_fall) begin
                    bad_n = 1'b0;
                    if (LJ) begin
                        shift_l = 1'b1;
                        cnt_n   = CW'(1);
                        state_n = SHIFT_L;
                    end else begin
                        state_n = DLY_L;
                    end
                end
            end
            DLY_L: begin
                cnt_n   = '0;
                state_n = SHIFT_L;
            end
            SHIFT_L: begin
                if (lr_rise && (LJ || !cnt_last)) begin
                    err_evt = 1'b1;
                    bad_n   = 1'b1;
                    if (LJ) begin
                        shift_r = 1'b1;
                        cnt_n   = CW'(1);
                        state_n = SHIFT_R;
                    end else begin
                        state_n = DLY_R;
                    end
                end else if (bclk_rise) begin
                    shift_l = 1'b1;
                    if (cnt_last) state_n = lr_rise ? DLY_R : WAIT_R;
                    else          cnt_n   = cnt + 1'b1;
                end
            end
            WAIT_R: begin
                if (lr_rise) begin
                    if (LJ) begin
                        shift_r = 1'b1;
                        cnt_n   = CW'(1);
                        state_n = SHIFT_R;
                    end else begin
                        state_n = DLY_R;
                    end
                end
            end
            DLY_R: begin
                cnt_n   = '0;
                state_n = SHIFT_R;
            end
            SHIFT_R: begin
                if (lr_fall && (LJ || !cnt_last)) begin
                    err_evt = 1'b1;
                    bad_n   = 1'b0;
                    if (LJ) begin
                        shift_l = 1'b1;
                        cnt_n   = CW'(1);
                        state_n = SHIFT_L;
                    end else begin
                        state_n = DLY_L;
                    end
                end else if (bclk_rise) begin
                    shift_r = 1'b1;
                    if (!cnt_last) begin
                        cnt_n = cnt + 1'b1;
                    end else if (bad) begin
                        // Left half was truncated: drop the frame rather than emit a lone right.
                        bad_n   = 1'b0;
                        state_n = lr_fall ? DLY_L : WAIT_L;
                    end else begin
                        pend_n  = lr_fall;
                        state_n = PUSH;
                    end
                end
            end
            PUSH: begin
                push    = 1'b1;
                pend_n  = 1'b0;
                state_n = pend ? DLY_L : WAIT_L;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            cnt   <= '0;
            bad   <= 1'b0;
            pend  <= 1'b0;
            sh_l  <= '0;
            sh_r  <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            bad   <= bad_n;
            pend  <= pend_n;
            if (shift_l) sh_l <= {sh_l[DW-2:0], dat_s};
            if (shift_r) sh_r <= {sh_r[DW-2:0], dat_s};
        end
    end

    // A push into a full FIFO is still accepted when a pop frees the head in the same cycle.
    assign rd_ok   = rd & ~empty;
    assign wr_ok   = push & (~full | rd_ok);
    assign ovf_evt = push & full & ~rd_ok;

    // NOTE: frame storage has no reset; count gates every read so stale contents never leak out.
    always_ff @(posedge clk) begin
        if (wr_ok) mem[wptr] <= {sh_l, sh_r};
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wptr        <= '0;
            rptr        <= '0;
            count       <= '0;
            sample_tick <= 1'b0;
            overrun     <= 1'b0;
            frame_err   <= 1'b0;
        end else begin
            if (wr_ok) wptr <= wptr + 1'b1;
            if (rd_ok) rptr <= rptr + 1'b1;
            case ({wr_ok, rd_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            sample_tick <= push;
            if (ovf_evt)      overrun <= 1'b1;
            else if (clr_err) overrun <= 1'b0;
            if (err_evt)      frame_err <= 1'b1;
            else if (clr_err) frame_err <= 1'b0;
        end
    end

    assign empty        = (count == '0);
    assign full         = (count == CNT_FULL);
    assign adc_data_out = empty ? '0 : mem[rptr];

endmodule

// File: tb/tb_adc_i2s_rx.sv
// tb_adc_i2s_rx: directed bench for adc_i2s_rx; streams I2S (or left-justified under
// ADC_I2S_RX_LJ_EN) frames and compares captured data, FIFO status and sticky flags.
module tb_adc_i2s_rx;

    localparam int DW = 16;
`ifdef ADC_I2S_RX_LJ_EN
    localparam bit LJ = 1'b1;
`else
    localparam bit LJ = 1'b0;
`endif

    typedef struct {
        logic [DW-1:0]   l;
        logic [DW-1:0]   r;
        logic [2*DW-1:0] exp;
    } vec_t;

    logic            clk;
    logic            reset_n;
    logic            b_clk;
    logic            adc_lr_clk;
    logic            adcdat;
    logic            rd;
    logic            clr_err;
    logic [2*DW-1:0] adc_data_out;
    logic            empty;
    logic            full;
    logic            sample_tick;
    logic            overrun;
    logic            frame_err;

    int   n_checks = 0;
    int   n_fail   = 0;
    int   ticks    = 0;
    logic tail_bit = 1'b0;

    adc_i2s_rx #(.DW(DW), .FIFO_AW(2), .SYNC_STAGES(2)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .b_clk        (b_clk),
        .adc_lr_clk   (adc_lr_clk),
        .adcdat       (adcdat),
        .rd           (rd),
        .clr_err      (clr_err),
        .adc_data_out (adc_data_out),
        .empty        (empty),
        .full         (full),
        .sample_tick  (sample_tick),
        .overrun      (overrun),
        .frame_err    (frame_err)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    // Sampled at the edge, so this sees the registered pulse's pre-edge value.
    always @(posedge clk) if (sample_tick === 1'b1) ticks = ticks + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // One bit-clock period of 8 clk: data and LR change with the falling edge.
    task automatic send_bit(input logic lr, input logic d, input bit pulse_rd);
        b_clk      = 1'b0;
        adc_lr_clk = lr;
        adcdat     = d;
        repeat (4) @(negedge clk);
        b_clk = 1'b1;
        if (pulse_rd) begin
            // The push lands 3 clk after this rising edge (2 sync flops + PUSH state).
            repeat (3) @(negedge clk);
            rd = 1'b1;
            @(negedge clk);
            rd = 1'b0;
            check("tick_with_rd", 32'(sample_tick), 32'd1);
        end else begin
            repeat (4) @(negedge clk);
        end
    endtask

    // nleft = number of LR-low slots; anything below DW truncates the left channel.
    task automatic frame(input logic [DW-1:0] l, input logic [DW-1:0] r, input int nleft,
                         input bit pulse_last);
        if (LJ) begin
            for (int i = 0; i < nleft; i++) send_bit(1'b0, l[DW-1-i], 1'b0);
            for (int i = 0; i < DW; i++) send_bit(1'b1, r[DW-1-i], pulse_last && (i == DW-1));
            tail_bit = 1'b0;
        end else begin
            send_bit(1'b0, tail_bit, 1'b0);
            for (int i = 1; i < nleft; i++) send_bit(1'b0, l[DW-i], 1'b0);
            send_bit(1'b1, l[DW-nleft], 1'b0);
            for (int i = 1; i < DW; i++) send_bit(1'b1, r[DW-i], 1'b0);
            tail_bit = r[0];
        end
    endtask

    // I2S delivers the right LSB in the first slot of the following frame.
    task automatic close(input bit pulse_rd);
        if (!LJ) send_bit(1'b0, tail_bit, pulse_rd);
    endtask

    task automatic restart();
        reset_n    = 1'b0;
        b_clk      = 1'b1;
        adc_lr_clk = 1'b1;
        adcdat     = 1'b0;
        rd         = 1'b0;
        clr_err    = 1'b0;
        tail_bit   = 1'b0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        repeat (2) send_bit(1'b1, 1'b0, 1'b0);
    endtask

    task automatic settle();
        repeat (6) @(negedge clk);
    endtask

    task automatic pop();
        rd = 1'b1;
        @(negedge clk);
        rd = 1'b0;
        @(negedge clk);
    endtask

    task automatic pulse_clr();
        clr_err = 1'b1;
        @(negedge clk);
        clr_err = 1'b0;
        @(negedge clk);
    endtask

    vec_t        vecs [5];
    logic [31:0] fr   [5];
    int          t0;

    initial begin
        vecs[0] = '{16'hA5C3, 16'h0F81, 32'hA5C3_0F81};
        vecs[1] = '{16'h1234, 16'h5678, 32'h1234_5678};
        vecs[2] = '{16'hFFFF, 16'h0000, 32'hFFFF_0000};
        vecs[3] = '{16'h8001, 16'h7FFE, 32'h8001_7FFE};
        vecs[4] = '{16'h0001, 16'h8000, 32'h0001_8000};
        fr[0] = 32'h1111_2222;
        fr[1] = 32'h3333_4444;
        fr[2] = 32'h5555_6666;
        fr[3] = 32'h7777_8888;
        fr[4] = 32'h9999_AAAA;

        reset_n = 1'b0; b_clk = 1'b1; adc_lr_clk = 1'b1; adcdat = 1'b0; rd = 1'b0; clr_err = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_data",        adc_data_out,      32'h0);
        check("rst_empty",       32'(empty),        32'd1);
        check("rst_full",        32'(full),         32'd0);
        check("rst_sample_tick", 32'(sample_tick),  32'd0);
        check("rst_overrun",     32'(overrun),      32'd0);
        check("rst_frame_err",   32'(frame_err),    32'd0);

        // Single frames from the vector table.
        for (int i = 0; i < 5; i++) begin
            restart();
            t0 = ticks;
            check($sformatf("vec%0d_empty_before", i), 32'(empty), 32'd1);
            frame(vecs[i].l, vecs[i].r, DW, 1'b0);
            close(1'b0);
            settle();
            check($sformatf("vec%0d_data", i),      adc_data_out,     vecs[i].exp);
            check($sformatf("vec%0d_empty", i),     32'(empty),       32'd0);
            check($sformatf("vec%0d_ticks", i),     32'(ticks - t0),  32'd1);
            check($sformatf("vec%0d_frame_err", i), 32'(frame_err),   32'd0);
            pop();
            check($sformatf("vec%0d_empty_after_rd", i), 32'(empty),  32'd1);
        end

        // Five frames, no reads: the fifth is dropped.
        restart();
        t0 = ticks;
        for (int i = 0; i < 5; i++) frame(fr[i][31:16], fr[i][15:0], DW, 1'b0);
        close(1'b0);
        settle();
        check("ovf_ticks",   32'(ticks - t0), 32'd5);
        check("ovf_full",    32'(full),       32'd1);
        check("ovf_overrun", 32'(overrun),    32'd1);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("ovf_read%0d", i), adc_data_out, fr[i]);
            pop();
            if (i == 0) check("ovf_full_after_rd", 32'(full), 32'd0);
        end
        check("ovf_empty_after_reads", 32'(empty),   32'd1);
        check("ovf_overrun_sticky",    32'(overrun), 32'd1);
        pulse_clr();
        check("ovf_overrun_cleared",   32'(overrun), 32'd0);

        // Full FIFO, read coincident with the fifth push.
        restart();
        for (int i = 0; i < 4; i++) frame(fr[i][31:16], fr[i][15:0], DW, 1'b0);
        frame(fr[4][31:16], fr[4][15:0], DW, LJ);
        close(!LJ);
        settle();
        check("rdpush_overrun", 32'(overrun), 32'd0);
        check("rdpush_full",    32'(full),    32'd1);
        for (int i = 1; i < 5; i++) begin
            check($sformatf("rdpush_read%0d", i), adc_data_out, fr[i]);
            pop();
        end
        check("rdpush_empty", 32'(empty), 32'd1);

        // Truncated left channel, then a good frame.
        restart();
        t0 = ticks;
        frame(16'hDEAD, 16'hBEEF, 10, 1'b0);
        frame(16'h1234, 16'h5678, DW, 1'b0);
        close(1'b0);
        settle();
        check("ferr_flag",  32'(frame_err),   32'd1);
        check("ferr_ticks", 32'(ticks - t0),  32'd1);
        check("ferr_data",  adc_data_out,     32'h1234_5678);
        pop();
        check("ferr_only_one_frame", 32'(empty), 32'd1);
        pulse_clr();
        check("ferr_cleared", 32'(frame_err), 32'd0);

        // Reset asserted mid right channel.
        restart();
        frame(16'hDEAD, 16'hBEEF, 10, 1'b0);
        frame(16'hAAAA, 16'h5555, DW, 1'b0);
        send_bit(1'b0, tail_bit, 1'b0);
        for (int i = 1; i < DW; i++) send_bit(1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 6; i++) send_bit(1'b1, 1'(i % 2), 1'b0);
        check("mid_pre_empty",     32'(empty),     32'd0);
        check("mid_pre_frame_err", 32'(frame_err), 32'd1);
        #3 reset_n = 1'b0;
        #1;
        check("mid_rst_empty",     32'(empty),       32'd1);
        check("mid_rst_data",      adc_data_out,     32'h0);
        check("mid_rst_full",      32'(full),        32'd0);
        check("mid_rst_tick",      32'(sample_tick), 32'd0);
        check("mid_rst_overrun",   32'(overrun),     32'd0);
        check("mid_rst_frame_err", 32'(frame_err),   32'd0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        t0 = ticks;
        for (int i = 0; i < 10; i++) send_bit(1'b1, 1'b1, 1'b0);
        frame(16'h0F0F, 16'hF0F0, DW, 1'b0);
        close(1'b0);
        settle();
        check("mid_after_ticks",     32'(ticks - t0),  32'd1);
        check("mid_after_data",      adc_data_out,     32'h0F0F_F0F0);
        check("mid_after_frame_err", 32'(frame_err),   32'd0);
        pop();
        check("mid_after_empty",     32'(empty),       32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
